// File: rtl/front_panel_ctrl.sv
// Front-panel button controller: synchronise/debounce three buttons, issue command strobes, await sequencer ack.
// Optional fetched-instruction counter enabled by defining FRONT_PANEL_INSTR_COUNTER_EN.
module front_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STROBE_LEN      = 2,
    parameter int ACK_TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_sst,
    input  logic        btn_halt,
    input  logic        running,
    input  logic        stb_fetch,
    output logic        startstop,
    output logic        sst,
    output logic        halt,
    output logic        busy,
    output logic        ack_err,
    output logic [15:0] instr_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(STROBE_LEN + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_ACK, S_RELEASE} state_t;
    typedef enum logic [1:0] {CMD_RUN, CMD_SST, CMD_HALT} cmd_t;

    // Bit order for all per-button vectors: [0] run, [1] sst, [2] halt.
    logic [2:0]    r_sync1, r_sync2, r_level, r_level_d, r_evt;
    logic [CW-1:0] r_db_cnt [3];

    state_t        r_state;
    cmd_t          r_cmd;
    logic          r_run_at_press;
    logic          r_seen_run;
    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_tmo;
    logic [1:0]    r_warm;
    logic          w_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            r_evt     <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1   <= {btn_halt, btn_sst, btn_run};
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_evt     <= r_level & ~r_level_d;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_level[i]) begin
                    if (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_level[i]  <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        w_ack = 1'b0;
        case (r_cmd)
            CMD_RUN:  w_ack = r_run_at_press ? !running : running;
            CMD_HALT: w_ack = !running;
            default:  w_ack = r_seen_run && !running;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RELEASE;
            r_cmd          <= CMD_RUN;
            r_run_at_press <= 1'b0;
            r_seen_run     <= 1'b0;
            r_pcnt         <= '0;
            r_tmo          <= '0;
            r_warm         <= '0;
            startstop      <= 1'b0;
            sst            <= 1'b0;
            halt           <= 1'b0;
            ack_err        <= 1'b0;
        end else begin
            if (r_warm != 2'd2) r_warm <= r_warm + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_run_at_press <= running;
                    r_seen_run     <= 1'b0;
                    r_pcnt         <= '0;
                    if (r_evt[2]) begin
                        if (!running) r_state <= S_RELEASE;
                        else begin
                            r_cmd   <= CMD_HALT;
                            halt    <= 1'b1;
                            r_state <= S_PULSE;
                        end
                    end else if (r_evt[0]) begin
                        r_cmd     <= CMD_RUN;
                        startstop <= 1'b1;
                        r_state   <= S_PULSE;
                    end else if (r_evt[1]) begin
                        if (running) r_state <= S_RELEASE;
                        else begin
                            r_cmd   <= CMD_SST;
                            sst     <= 1'b1;
                            r_state <= S_PULSE;
                        end
                    end
                end
                S_PULSE: begin
                    if (running) r_seen_run <= 1'b1;
                    if (r_pcnt == PW'(STROBE_LEN - 1)) begin
                        startstop <= 1'b0;
                        sst       <= 1'b0;
                        halt      <= 1'b0;
                        r_tmo     <= '0;
                        r_state   <= S_WAIT_ACK;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (running) r_seen_run <= 1'b1;
                    if (w_ack) r_state <= S_RELEASE;
                    else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                        ack_err <= 1'b1;
                        r_state <= S_RELEASE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    // The synchroniser must have refilled and show no press, so a button held through reset cannot re-arm.
                    if (r_warm == 2'd2 && r_level == 3'b000 && r_sync2 == 3'b000) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

`ifdef FRONT_PANEL_INSTR_COUNTER_EN
    logic [15:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_instr_cnt <= '0;
        else if (stb_fetch && running) r_instr_cnt <= r_instr_cnt + 16'd1;
    end

    assign instr_count = r_instr_cnt;
`else
    logic w_unused_fetch;

    assign w_unused_fetch = stb_fetch;
    assign instr_count    = 16'h0000;
`endif

endmodule
